pipelined_tightly_coupled_negator: RTL and testbench
====================================================

// Module: pipelined_tightly_coupled_negator
// PURPOSE
//  Multi-lane two's-complement negator with a fixed 2-cycle pipeline and no back-pressure.
//  Sits between the decrypt engine and the encrypt engine in the encrypted negation datapath.
//  The datapath streams one 64-bit word per cycle (2 x 32-bit integers) and samples results
//  exactly 2 cycles later.
// PARAMETERS
//  WIDTH_IN_NUM_OF_FULL_INTEGER  2   number of independent integer lanes (N)
//  INTEGER_WIDTH                 32  bits per lane (IW); bus width = N*IW
// PORTS
//  clock         input   1     single clock; all state updates on posedge
//  reset         input   1     synchronous, active-high; clears all pipeline state
//  input_valid   input   N     per-lane valid; bit i qualifies input_data lane i
//  input_data    input   N*IW  lane i = input_data[i*IW +: IW]
//  output_valid  output  N     per-lane valid, registered
//  output_data   output  N*IW  lane i = negated lane i, registered
// BEHAVIOUR
//  - Tightly coupled: no ready/stall. A new input is accepted every cycle; nothing is ever dropped or held.
//  - Per lane, two register stages:
//    - S1 captures {input_valid[i], input_data lane i} unconditionally each cycle.
//    - S2 captures {S1.valid, S1.valid ? (~S1.data + 1) : 0}.
//  - Outputs are driven directly from the S2 registers, with no combinational path from inputs.
//  - Latency: input presented in cycle T (sampled at edge T) appears on the outputs during cycle T+2.
//    Throughput is 1 word/cycle.
//  - Arithmetic: modulo 2^IW two's complement per lane. No carry between lanes.
//    Boundary values: 0 -> 0; 1 -> all ones; most-negative (0x8000_0000) -> 0x8000_0000, wraps with no flag.
//  - Lanes are fully independent. Mixed valid patterns (e.g. 2'b01) negate only the valid lanes.
//  - Invalid lanes produce output_data lane = 0 and output_valid bit = 0. Input data on invalid lanes is ignored.
//  - Reset:
//    - All S1/S2 valid and data registers go to 0, so output_valid = 0 and output_data = 0 from the cycle after the reset edge.
//    - Reset asserted mid-stream discards all in-flight words; none reappear after reset deasserts.
//    - The first input after deassertion follows normal 2-cycle latency.
//  - Back-to-back inputs in consecutive cycles emerge in consecutive cycles, in order.
//  - Bubbles (valid = 0) are preserved in position.
//  - No internal state beyond the 2 stages: 2*N*(IW+1) flops total.
// TESTING
//  1. Reset:
//     - Hold reset 3 cycles with random inputs -> output_valid=0, output_data=0 throughout and 1 cycle after release.
//  2. Single word:
//     - Stimulus: valid=2'b11, data=64'h0000_0005_0000_0001 at T.
//     - Expected at T+2: valid=2'b11, data=64'hFFFF_FFFB_FFFF_FFFF.
//     - Expected at T+1 and T+3 (idle input): valid=0.
//  3. Boundaries:
//     - Stimulus: data=64'h8000_0000_0000_0000, valid=2'b11.
//     - Expected after 2 cycles: data=64'h8000_0000_0000_0000.
//     - Also check lane FFFF_FFFF -> 0000_0001.
//  4. Streaming:
//     - Stimulus: 8 consecutive random valid words.
//     - Expected: 8 consecutive results starting 2 cycles later, each lane == -x mod 2^32, in order.
//  5. Lane masking:
//     - Stimulus: valid=2'b01, data=64'h1234_5678_0000_0002.
//     - Expected: valid=2'b01, data=64'h0000_0000_FFFF_FFFE.
//     - Repeat with valid=2'b10 and check the mirrored result.
//  6. Reset mid-pipeline:
//     - Stimulus: words at T and T+1, reset at T+1.
//     - Expected: no valid output at T+2 or T+3; a word issued after release appears 2 cycles later.

Source files
------------

// File: rtl/pipelined_tightly_coupled_negator.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_tightly_coupled_negator
//  Description : Multi-lane two's-complement negator. Each lane is carried
//                through two register stages (capture, then negate) with no
//                back-pressure; one word is accepted every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_tightly_coupled_negator #(
    parameter int WIDTH_IN_NUM_OF_FULL_INTEGER = 2,
    parameter int INTEGER_WIDTH                = 32
) (
    input  logic                                                    clock,
    input  logic                                                    reset,
    input  logic [WIDTH_IN_NUM_OF_FULL_INTEGER-1:0]                 input_valid,
    input  logic [WIDTH_IN_NUM_OF_FULL_INTEGER*INTEGER_WIDTH-1:0]   input_data,
    output logic [WIDTH_IN_NUM_OF_FULL_INTEGER-1:0]                 output_valid,
    output logic [WIDTH_IN_NUM_OF_FULL_INTEGER*INTEGER_WIDTH-1:0]   output_data
);

    localparam int          c_N   = WIDTH_IN_NUM_OF_FULL_INTEGER;
    localparam int          c_IW  = INTEGER_WIDTH;
    localparam logic [c_IW-1:0] c_ONE = {{(c_IW-1){1'b0}}, 1'b1};

    // Lanes are fully independent: each gets its own two-stage pipeline and
    // its own adder, so no carry can ever cross a lane boundary.
    for (genvar i = 0; i < c_N; i++) begin : g_lane
        logic            s1_valid_q;
        logic [c_IW-1:0] s1_data_q;
        logic            s2_valid_q;
        logic [c_IW-1:0] s2_data_q;
        logic [c_IW-1:0] s2_data_d;

        // Stage 1: capture the raw lane every cycle, qualified or not.
        always_ff @(posedge clock) begin
            if (reset) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= input_valid[i];
                s1_data_q  <= input_data[i*c_IW +: c_IW];
            end
        end

        // Negate modulo 2^IW; invalid lanes are forced to zero so stale data never leaks out.
        always_comb begin
            s2_data_d = '0;
            if (s1_valid_q) begin
                s2_data_d = (~s1_data_q) + c_ONE;
            end
        end

        // Stage 2: register the result; outputs come straight from these flops.
        always_ff @(posedge clock) begin
            if (reset) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_data_q  <= s2_data_d;
            end
        end

        assign output_valid[i]                = s2_valid_q;
        assign output_data[i*c_IW +: c_IW]    = s2_data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_tightly_coupled_negator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_tightly_coupled_negator
//  Description : Self-checking bench for the 2-lane, 2-cycle negator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_tightly_coupled_negator;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  input_valid;
    logic [63:0] input_data;
    logic [1:0]  output_valid;
    logic [63:0] output_data;

    pipelined_tightly_coupled_negator #(
        .WIDTH_IN_NUM_OF_FULL_INTEGER (2),
        .INTEGER_WIDTH                (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_data  (output_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  ev;
        logic [63:0] ed;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0]  v;
        logic [63:0] d;
        logic [1:0]  ev;
        logic [63:0] ed;
        string       name;
    } vec_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference: per-lane 0 - x modulo 2^32, invalid lanes zero.
    function automatic logic [63:0] neg_model(input logic [1:0] v, input logic [63:0] d);
        logic [31:0] l0, l1;
        l0 = v[0] ? (32'd0 - d[31:0])  : 32'd0;
        l1 = v[1] ? (32'd0 - d[63:32]) : 32'd0;
        return {l1, l0};
    endfunction

    task automatic check(input string name, input logic [1:0] ev, input logic [63:0] ed);
        n_total++;
        if (output_valid === ev && output_data === ed) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got valid=%b data=%h, want valid=%b data=%h",
                     name, output_valid, output_data, ev, ed);
        end
    endtask

    // One clock cycle: drive inputs, push the expected result, compare the
    // result due this cycle (the one pushed two cycles earlier).
    task automatic step(input logic rst, input logic [1:0] v, input logic [63:0] d,
                        input logic [1:0] ev, input logic [63:0] ed, input string name);
        exp_t e;
        @(negedge clock);
        reset       = rst;
        input_valid = v;
        input_data  = d;
        @(posedge clock);
        #1;
        if (rst) begin
            // Everything in flight is discarded; S1 now holds zero.
            check({name, "_rst"}, 2'b00, 64'd0);
            exp_q.delete();
            e.ev = 2'b00; e.ed = 64'd0; e.name = {name, "_post"};
            exp_q.push_back(e);
        end else begin
            e.ev = ev; e.ed = ed; e.name = name;
            exp_q.push_back(e);
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                check(e.name, e.ev, e.ed);
            end
        end
    endtask

    task automatic idle(input string name);
        step(1'b0, 2'b00, 64'd0, 2'b00, 64'd0, name);
    endtask

    vec_t vecs[8];

    initial begin
        logic [63:0] rd;
        reset       = 1'b1;
        input_valid = '0;
        input_data  = '0;

        vecs[0] = '{2'b11, 64'h0000_0005_0000_0001, 2'b11, 64'hFFFF_FFFB_FFFF_FFFF, "five_one"};
        vecs[1] = '{2'b11, 64'h8000_0000_8000_0000, 2'b11, 64'h8000_0000_8000_0000, "most_neg"};
        vecs[2] = '{2'b11, 64'h8000_0000_0000_0000, 2'b11, 64'h8000_0000_0000_0000, "most_neg_zero"};
        vecs[3] = '{2'b11, 64'hFFFF_FFFF_0000_0000, 2'b11, 64'h0000_0001_0000_0000, "all_ones"};
        vecs[4] = '{2'b01, 64'h1234_5678_0000_0002, 2'b01, 64'h0000_0000_FFFF_FFFE, "mask_01"};
        vecs[5] = '{2'b10, 64'h1234_5678_0000_0002, 2'b10, 64'hEDCB_A988_0000_0000, "mask_10"};
        vecs[6] = '{2'b00, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 64'h0000_0000_0000_0000, "mask_00"};
        vecs[7] = '{2'b11, 64'h7FFF_FFFF_0000_0001, 2'b11, 64'h8000_0001_FFFF_FFFF, "max_pos"};

        // Reset held three cycles with random inputs, then one cycle after release.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'($urandom), {$urandom, $urandom}, 2'b00, 64'd0, "reset_hold");
        end
        idle("after_release");

        // Single word surrounded by idle cycles (T+1 and T+3 must be empty).
        step(1'b0, vecs[0].v, vecs[0].d, vecs[0].ev, vecs[0].ed, "single");
        idle("single_t1");
        idle("single_t3");
        idle("single_t4");

        // Directed table, back to back.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, vecs[i].v, vecs[i].d, vecs[i].ev, vecs[i].ed, vecs[i].name);
        end
        idle("tbl_drain0");
        idle("tbl_drain1");

        // Streaming: 8 consecutive random words, then a bubble pattern.
        for (int i = 0; i < 8; i++) begin
            rd = {$urandom, $urandom};
            step(1'b0, 2'b11, rd, 2'b11, neg_model(2'b11, rd), "stream");
        end
        for (int i = 0; i < 8; i++) begin
            logic [1:0] v;
            v  = (i % 3 == 1) ? 2'b00 : 2'($urandom);
            rd = {$urandom, $urandom};
            step(1'b0, v, rd, v, neg_model(v, rd), "bubbles");
        end
        idle("stream_drain0");
        idle("stream_drain1");

        // Reset mid-pipeline: words at T and T+1, reset sampled at T+1.
        step(1'b0, 2'b11, 64'h0000_0001_0000_0002, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, "midrst_w0");
        step(1'b1, 2'b11, 64'h0000_0003_0000_0004, 2'b00, 64'd0, "midrst_w1");
        idle("midrst_t3");
        step(1'b0, 2'b11, 64'h0000_0009_0000_000A, 2'b11, 64'hFFFF_FFF7_FFFF_FFF6, "midrst_after");
        idle("midrst_drain0");
        idle("midrst_drain1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
